spi_slave_regif: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_slave_regif_sync.sv | 33 +++
 rtl/spi_slave_regif.sv | 158 +++++++++++++++
 tb/tb_spi_slave_regif.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI register-bus responder: synchroniser depth,
// default frame geometry and the FSM state encoding.
package spi_slave_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int HDR_W_DEF   = 16;
    localparam int DAT_W_DEF   = 8;
    localparam int FRM_LEN_DEF = HDR_W_DEF + DAT_W_DEF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR     = 3'd1;
    localparam state_t ST_RD_WAIT = 3'd2;
    localparam state_t ST_RD_DATA = 3'd3;
    localparam state_t ST_WR_DATA = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    function automatic int frm_len(input int hdr_w, input int dat_w);
        return hdr_w + dat_w;
    endfunction

endpackage

// File: rtl/spi_slave_regif_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus an edge register
// that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
)(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            edge_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~edge_q;
    assign fall  = ~level & edge_q;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI responder that turns each header+data frame into one register-bus
// read or write access. All SPI pins are oversampled in the clk_i domain.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | CS high, MISO released
// HDR     | shifting in the R/W flag and address
// RD_WAIT | read strobe issued, waiting for ack or first data fall edge
// RD_DATA | driving read data on MISO
// WR_DATA | shifting in write data
// DONE    | frame complete, extra SPI clocks ignored until CS rises
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DAT_W  = DAT_W_DEF,
    parameter int HDR_W  = HDR_W_DEF
)(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              spi_cs_i,
    input  logic              spi_clk_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_t,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DAT_W-1:0]  reg_wdata_o,
    output logic              reg_wen_o,
    output logic              reg_ren_o,
    input  logic [DAT_W-1:0]  reg_rdata_i,
    input  logic              reg_ack_i,
    output logic              frm_done_o,
    output logic              frm_abort_o,
    output logic              rd_late_o
);

    localparam int         FRM_LEN  = frm_len(HDR_W, DAT_W);
    localparam logic [4:0] HDR_LAST = 5'(HDR_W - 1);
    localparam logic [4:0] HDR_CNT  = 5'(HDR_W);
    localparam logic [4:0] FRM_LAST = 5'(FRM_LEN - 1);

    logic cs_lvl_unused, cs_rise, cs_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_i (clk_i), .rstn_i (rstn_i), .d (spi_cs_i),
        .level (cs_lvl_unused), .rise (cs_rise), .fall (cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk_i (clk_i), .rstn_i (rstn_i), .d (spi_clk_i),
        .level (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk_i), .rstn_i (rstn_i), .d (spi_mosi_i),
        .level (mosi_lvl), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
    );

    state_t           state_q;
    logic [4:0]       bit_cnt_q;
    logic [HDR_W-2:0] hdr_q;
    logic [DAT_W-2:0] rx_q;
    logic [DAT_W-1:0] tx_q;
    logic [HDR_W-1:0] hdr_nxt;
    logic [DAT_W-1:0] rx_nxt;

    assign hdr_nxt = {hdr_q, mosi_lvl};
    assign rx_nxt  = {rx_q, mosi_lvl};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            hdr_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '1;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wen_o   <= 1'b0;
            reg_ren_o   <= 1'b0;
            frm_done_o  <= 1'b0;
            frm_abort_o <= 1'b0;
            rd_late_o   <= 1'b0;
        end else begin
            reg_wen_o   <= 1'b0;
            reg_ren_o   <= 1'b0;
            frm_done_o  <= 1'b0;
            frm_abort_o <= 1'b0;
            rd_late_o   <= 1'b0;
            if (cs_rise && state_q != ST_IDLE) begin
                frm_abort_o <= (state_q != ST_DONE);
                state_q     <= ST_IDLE;
            end else if (cs_fall && (state_q == ST_IDLE || state_q == ST_DONE)) begin
                state_q   <= ST_HDR;
                bit_cnt_q <= '0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
                case (state_q)
                    ST_HDR: begin
                        if (sclk_rise) begin
                            hdr_q <= hdr_nxt[HDR_W-2:0];
                            if (bit_cnt_q == HDR_LAST) begin
                                reg_addr_o <= hdr_nxt[ADDR_W-1:0];
                                if (hdr_nxt[HDR_W-1]) begin
                                    reg_ren_o <= 1'b1;
                                    state_q   <= ST_RD_WAIT;
                                end else begin
                                    state_q <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_RD_WAIT: begin
                        if (reg_ack_i) begin
                            tx_q    <= reg_rdata_i;
                            state_q <= ST_RD_DATA;
                        end else if (sclk_fall) begin
                            tx_q      <= '0;
                            rd_late_o <= 1'b1;
                            state_q   <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        // The first data bit is presented on entry, so the fall
                        // edge preceding data rise edge HDR_W+1 must not shift.
                        if (sclk_fall && bit_cnt_q > HDR_CNT) begin
                            tx_q <= {tx_q[DAT_W-2:0], 1'b0};
                        end
                        if (sclk_rise && bit_cnt_q == FRM_LAST) begin
                            frm_done_o <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                    ST_WR_DATA: begin
                        if (sclk_rise) begin
                            rx_q <= rx_nxt[DAT_W-2:0];
                            if (bit_cnt_q == FRM_LAST) begin
                                reg_wdata_o <= rx_nxt;
                                reg_wen_o   <= 1'b1;
                                frm_done_o  <= 1'b1;
                                state_q     <= ST_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_miso_o = tx_q[DAT_W-1];
    assign spi_miso_t = (state_q != ST_RD_DATA);

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: a bit-banged SPI master, a small register block
// responder, and a reference register array that predicts every read.
module tb_spi_slave_regif;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       spi_cs_i, spi_clk_i, spi_mosi_i;
    logic       spi_miso_o, spi_miso_t;
    logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
    logic       reg_wen_o, reg_ren_o, reg_ack_i;
    logic       frm_done_o, frm_abort_o, rd_late_o;

    spi_slave_regif dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .spi_cs_i    (spi_cs_i),
        .spi_clk_i   (spi_clk_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_miso_o  (spi_miso_o),
        .spi_miso_t  (spi_miso_t),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wen_o   (reg_wen_o),
        .reg_ren_o   (reg_ren_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_ack_i   (reg_ack_i),
        .frm_done_o  (frm_done_o),
        .frm_abort_o (frm_abort_o),
        .rd_late_o   (rd_late_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register block seen by the DUT, plus pulse counters.
    logic [7:0] rf_mem [256] = '{default: 8'h00};
    int         cnt_wen = 0, cnt_ren = 0, cnt_done = 0, cnt_abort = 0, cnt_late = 0, cnt_both = 0;
    logic [7:0] last_waddr = 8'h00, last_wdata = 8'h00;

    always @(negedge clk_i) begin
        if (reg_wen_o) begin
            cnt_wen++;
            last_waddr = reg_addr_o;
            last_wdata = reg_wdata_o;
            rf_mem[reg_addr_o] = reg_wdata_o;
        end
        if (reg_ren_o)              cnt_ren++;
        if (frm_done_o)             cnt_done++;
        if (frm_abort_o)            cnt_abort++;
        if (rd_late_o)              cnt_late++;
        if (reg_wen_o && reg_ren_o) cnt_both++;
    end

    int ack_dly = 1;

    initial begin
        int ack_cnt;
        ack_cnt     = 0;
        reg_ack_i   = 1'b0;
        reg_rdata_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            reg_ack_i = 1'b0;
            if (reg_ren_o) ack_cnt = ack_dly + 1;
            if (ack_cnt == 1) begin
                reg_ack_i   = 1'b1;
                reg_rdata_i = rf_mem[reg_addr_o];
            end
            if (ack_cnt > 0) ack_cnt--;
        end
    end

    int b_wen, b_ren, b_done, b_abort, b_late;

    task automatic snap();
        b_wen   = cnt_wen;
        b_ren   = cnt_ren;
        b_done  = cnt_done;
        b_abort = cnt_abort;
        b_late  = cnt_late;
    endtask

    // Master: drives on the falling edge, samples MISO on the rising edge.
    task automatic spi_frame(input logic [15:0] hdr, input logic [7:0] wd, input int half,
                             input int n_bits, output logic [7:0] rd, output int tri_err);
        logic [23:0] frame;
        logic        exp_t;
        frame   = {hdr, wd};
        rd      = 8'h00;
        tri_err = 0;
        spi_cs_i = 1'b0;
        repeat (half) @(posedge clk_i);
        for (int i = 0; i < n_bits; i++) begin
            #1;
            spi_clk_i  = 1'b0;
            spi_mosi_i = frame[23-i];
            repeat (half) @(posedge clk_i);
            #1;
            spi_clk_i = 1'b1;
            exp_t = !(hdr[15] && i >= 16);
            if (spi_miso_t !== exp_t) tri_err++;
            if (i >= 16) rd = {rd[6:0], spi_miso_o};
            repeat (half) @(posedge clk_i);
        end
        #1;
        spi_cs_i = 1'b1;
        repeat (2 * half + 10) @(posedge clk_i);
        #1;
        if (spi_miso_t !== 1'b1) tri_err++;
    endtask

    logic [7:0] ref_mem [256];
    logic [7:0] rd;
    int         terr;
    logic [7:0] r_addr, r_data;
    logic [6:0] r_hi;
    logic       r_rw;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rstn_i     = 1'b0;
        spi_cs_i   = 1'b1;
        spi_clk_i  = 1'b1;
        spi_mosi_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ctl", 32'({spi_miso_t, spi_miso_o, reg_wen_o, reg_ren_o, frm_done_o, frm_abort_o, rd_late_o}), 'h60);
        chk("rst_addr", 32'(reg_addr_o), 0);
        chk("rst_wdata", 32'(reg_wdata_o), 0);
        rstn_i = 1'b1;
        repeat (5) @(posedge clk_i);

        // Plain write at the slow rate.
        snap();
        spi_frame(16'h0012, 8'hA5, 128, 24, rd, terr);
        ref_mem[8'h12] = 8'hA5;
        chk("wr_wen", 32'(cnt_wen - b_wen), 1);
        chk("wr_addr", 32'(last_waddr), 'h12);
        chk("wr_wdata", 32'(last_wdata), 'hA5);
        chk("wr_done", 32'(cnt_done - b_done), 1);
        chk("wr_ren", 32'(cnt_ren - b_ren), 0);
        chk("wr_tri", 32'(terr), 0);

        // Read with ack two cycles after the strobe.
        spi_frame(16'h0034, 8'h3C, 32, 24, rd, terr);
        ref_mem[8'h34] = 8'h3C;
        ack_dly = 2;
        snap();
        spi_frame(16'h8034, 8'h00, 32, 24, rd, terr);
        chk("rd_data", 32'(rd), 32'(ref_mem[8'h34]));
        chk("rd_addr", 32'(reg_addr_o), 'h34);
        chk("rd_ren", 32'(cnt_ren - b_ren), 1);
        chk("rd_wen", 32'(cnt_wen - b_wen), 0);
        chk("rd_late", 32'(cnt_late - b_late), 0);
        chk("rd_done", 32'(cnt_done - b_done), 1);
        chk("rd_tri", 32'(terr), 0);

        // Ack withheld past the first data fall edge, then a normal read.
        ack_dly = 100;
        snap();
        spi_frame(16'h8012, 8'h00, 32, 24, rd, terr);
        chk("late_data", 32'(rd), 0);
        chk("late_pulse", 32'(cnt_late - b_late), 1);
        chk("late_ren", 32'(cnt_ren - b_ren), 1);
        chk("late_done", 32'(cnt_done - b_done), 1);
        chk("late_tri", 32'(terr), 0);
        ack_dly = 1;
        snap();
        spi_frame(16'h8012, 8'h00, 32, 24, rd, terr);
        chk("after_late_data", 32'(rd), 32'(ref_mem[8'h12]));
        chk("after_late_pulse", 32'(cnt_late - b_late), 0);

        // CS raised after 20 rising edges of a write.
        snap();
        spi_frame(16'h0077, 8'hEE, 32, 20, rd, terr);
        chk("abort_pulse", 32'(cnt_abort - b_abort), 1);
        chk("abort_wen", 32'(cnt_wen - b_wen), 0);
        chk("abort_done", 32'(cnt_done - b_done), 0);
        chk("abort_tri", 32'(terr), 0);
        snap();
        spi_frame(16'h0001, 8'h55, 32, 24, rd, terr);
        ref_mem[8'h01] = 8'h55;
        chk("post_abort_wen", 32'(cnt_wen - b_wen), 1);
        chk("post_abort_addr", 32'(last_waddr), 'h01);
        chk("post_abort_wdata", 32'(last_wdata), 'h55);
        chk("post_abort_abort", 32'(cnt_abort - b_abort), 0);
        spi_frame(16'h8077, 8'h00, 32, 24, rd, terr);
        chk("abort_no_write", 32'(rd), 32'(ref_mem[8'h77]));

        // Asynchronous reset in the middle of a read data phase.
        fork
            spi_frame(16'h8001, 8'h00, 32, 24, rd, terr);
            begin
                repeat (32 + 19 * 64) @(posedge clk_i);
                #2;
                chk("rst_mid_pre_t", 32'(spi_miso_t), 0);
                rstn_i = 1'b0;
                #1;
                chk("rst_mid_ctl", 32'({spi_miso_t, spi_miso_o, reg_wen_o, reg_ren_o, frm_done_o, frm_abort_o, rd_late_o}), 'h60);
                chk("rst_mid_addr", 32'(reg_addr_o), 0);
                repeat (4) @(posedge clk_i);
                #1;
                rstn_i = 1'b1;
            end
        join
        snap();
        spi_frame(16'h8001, 8'h00, 32, 24, rd, terr);
        chk("rst_after_data", 32'(rd), 32'(ref_mem[8'h01]));
        chk("rst_after_tri", 32'(terr), 0);
        chk("rst_after_done", 32'(cnt_done - b_done), 1);

        // Random read/write traffic against the reference register array.
        for (int k = 0; k < 100; k++) begin
            r_addr  = 8'($urandom);
            r_hi    = 7'($urandom);
            r_data  = 8'($urandom);
            r_rw    = 1'($urandom_range(0, 1));
            ack_dly = $urandom_range(0, 2);
            snap();
            spi_frame({r_rw, r_hi, r_addr}, r_data, 8, 24, rd, terr);
            if (r_rw) chk("rnd_rdata", 32'(rd), 32'(ref_mem[r_addr]));
            else      ref_mem[r_addr] = r_data;
            chk("rnd_wen", 32'(cnt_wen - b_wen), r_rw ? 0 : 1);
            chk("rnd_ren", 32'(cnt_ren - b_ren), r_rw ? 1 : 0);
            chk("rnd_err", 32'((cnt_abort - b_abort) + (cnt_late - b_late)), 0);
            chk("rnd_tri", 32'(terr), 0);
        end

        chk("dual_strobe", 32'(cnt_both), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
